// File: rtl/sequential_normalizer.sv
// sequential_normalizer
//   Multi-cycle post-add/sub normalizer for the FPU add/sub path. It takes the
//   raw significand (with carry-out bit), the tentative exponent and the sign.
//   It produces a normalized significand, an adjusted exponent and the
//   Zero/Overflow/Underflow flags. Left shifts run one bit per clock.
//
// Ports:
//   Clk          rising-edge clock
//   ResetN       synchronous active-low reset
//   InValid      upstream result valid
//   InReady      block can accept (state == IDLE)
//   InMantissa   raw significand, bit MantSize is the carry-out
//   InExponent   tentative (larger) exponent
//   InSign       result sign
//   OutValid     normalized result valid (state == DONE)
//   OutReady     downstream accepts result
//   OutMantissa  normalized significand
//   OutExponent  adjusted exponent
//   OutSign      result sign (forced 0 on Zero)
//   Zero         result is exactly zero
//   Overflow     exponent saturated to all-ones
//   Underflow    result denormal, shifting stopped at exponent floor
module sequential_normalizer #(
   parameter int MantSize = 8,
   parameter int ExpSize  = 8
) (
   input  logic                Clk,
   input  logic                ResetN,
   input  logic                InValid,
   output logic                InReady,
   input  logic [MantSize:0]   InMantissa,
   input  logic [ExpSize-1:0]  InExponent,
   input  logic                InSign,
   output logic                OutValid,
   input  logic                OutReady,
   output logic [MantSize-1:0] OutMantissa,
   output logic [ExpSize-1:0]  OutExponent,
   output logic                OutSign,
   output logic                Zero,
   output logic                Overflow,
   output logic                Underflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NORM = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [MantSize:0]   WIDE_ZERO = {(MantSize+1){1'b0}};
   localparam logic [MantSize-1:0] MANT_ZERO = {MantSize{1'b0}};
   localparam logic [ExpSize-1:0]  EXP_ZERO  = {ExpSize{1'b0}};
   localparam logic [ExpSize-1:0]  EXP_ONE   = {{(ExpSize-1){1'b0}}, 1'b1};
   localparam logic [ExpSize-1:0]  EXP_MAX   = {ExpSize{1'b1}};
   // A carry at or above this exponent would land on the all-ones encoding.
   localparam logic [ExpSize-1:0]  EXP_OVF_TH = {{(ExpSize-1){1'b1}}, 1'b0};

   state_t              state_q, state_d;
   logic [MantSize:0]   m_q, m_d;
   logic [ExpSize-1:0]  e_q, e_d;
   logic                s_q, s_d;
   logic [MantSize-1:0] out_mant_q, out_mant_d;
   logic [ExpSize-1:0]  out_exp_q, out_exp_d;
   logic                out_sign_q, out_sign_d;
   logic                zero_q, zero_d;
   logic                ovf_q, ovf_d;
   logic                unf_q, unf_d;

   // Next-state and working-register computation for the IDLE/NORM/DONE FSM.
   always_comb begin
      state_d    = state_q;
      m_d        = m_q;
      e_d        = e_q;
      s_d        = s_q;
      out_mant_d = out_mant_q;
      out_exp_d  = out_exp_q;
      out_sign_d = out_sign_q;
      zero_d     = zero_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;

      case (state_q)
         ST_IDLE: begin
            if (InValid) begin
               m_d     = InMantissa;
               e_d     = InExponent;
               s_d     = InSign;
               zero_d  = 1'b0;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               state_d = ST_NORM;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_NORM: begin
            // Checks are strictly prioritised; only the last one keeps shifting.
            if (m_q == WIDE_ZERO) begin
               out_mant_d = MANT_ZERO;
               out_exp_d  = EXP_ZERO;
               out_sign_d = 1'b0;
               zero_d     = 1'b1;
               state_d    = ST_DONE;
            end else if (m_q[MantSize]) begin
               if (e_q >= EXP_OVF_TH) begin
                  out_mant_d = MANT_ZERO;
                  out_exp_d  = EXP_MAX;
                  ovf_d      = 1'b1;
               end else begin
                  out_mant_d = m_q[MantSize:1];
                  out_exp_d  = e_q + EXP_ONE;
               end
               out_sign_d = s_q;
               state_d    = ST_DONE;
            end else if (e_q == EXP_ZERO) begin
               out_mant_d = m_q[MantSize-1:0];
               out_exp_d  = e_q;
               out_sign_d = s_q;
               state_d    = ST_DONE;
            end else if (m_q[MantSize-1]) begin
               out_mant_d = m_q[MantSize-1:0];
               out_exp_d  = e_q;
               out_sign_d = s_q;
               state_d    = ST_DONE;
            end else if (e_q == EXP_ONE) begin
               // Exponent floor reached before the leading one: denormal.
               out_mant_d = m_q[MantSize-1:0];
               out_exp_d  = EXP_ZERO;
               out_sign_d = s_q;
               unf_d      = 1'b1;
               state_d    = ST_DONE;
            end else begin
               m_d     = {m_q[MantSize-1:0], 1'b0};
               e_d     = e_q - EXP_ONE;
               state_d = ST_NORM;
            end
         end

         ST_DONE: begin
            if (OutReady) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, working and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!ResetN) begin
         state_q    <= ST_IDLE;
         m_q        <= WIDE_ZERO;
         e_q        <= EXP_ZERO;
         s_q        <= 1'b0;
         out_mant_q <= MANT_ZERO;
         out_exp_q  <= EXP_ZERO;
         out_sign_q <= 1'b0;
         zero_q     <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         m_q        <= m_d;
         e_q        <= e_d;
         s_q        <= s_d;
         out_mant_q <= out_mant_d;
         out_exp_q  <= out_exp_d;
         out_sign_q <= out_sign_d;
         zero_q     <= zero_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign InReady     = (state_q == ST_IDLE);
   assign OutValid    = (state_q == ST_DONE);
   assign OutMantissa = out_mant_q;
   assign OutExponent = out_exp_q;
   assign OutSign     = out_sign_q;
   assign Zero        = zero_q;
   assign Overflow    = ovf_q;
   assign Underflow   = unf_q;

endmodule

// File: tb/tb_sequential_normalizer.sv
// Testbench for sequential_normalizer (MantSize=8, ExpSize=8).
// Expected results are queued when an operand is accepted and compared when
// OutValid rises, including the accept-to-DONE latency.
module tb_sequential_normalizer;

   logic       Clk;
   logic       ResetN;
   logic       InValid;
   logic       InReady;
   logic [8:0] InMantissa;
   logic [7:0] InExponent;
   logic       InSign;
   logic       OutValid;
   logic       OutReady;
   logic [7:0] OutMantissa;
   logic [7:0] OutExponent;
   logic       OutSign;
   logic       Zero;
   logic       Overflow;
   logic       Underflow;

   sequential_normalizer #(.MantSize(8), .ExpSize(8)) dut (
      .Clk         (Clk),
      .ResetN      (ResetN),
      .InValid     (InValid),
      .InReady     (InReady),
      .InMantissa  (InMantissa),
      .InExponent  (InExponent),
      .InSign      (InSign),
      .OutValid    (OutValid),
      .OutReady    (OutReady),
      .OutMantissa (OutMantissa),
      .OutExponent (OutExponent),
      .OutSign     (OutSign),
      .Zero        (Zero),
      .Overflow    (Overflow),
      .Underflow   (Underflow)
   );

   typedef struct {
      logic [7:0] mant;
      logic [7:0] expo;
      logic       sign;
      logic       zero;
      logic       ovf;
      logic       unf;
      int         lat;
      int         acc;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_v = 1'b0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Edge counter used to measure accept-to-DONE latency.
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] m, input logic [7:0] e, input logic s,
                               input logic z, input logic o, input logic u, input int lat);
      exp_t r;
      r.mant = m; r.expo = e; r.sign = s; r.zero = z; r.ovf = o; r.unf = u;
      r.lat = lat; r.acc = 0;
      return r;
   endfunction

   // Reference: count leading zeros, then limit the shift by the exponent floor.
   function automatic exp_t model(input logic [8:0] m, input logic [7:0] e, input logic s);
      exp_t r;
      int   ei;
      int   lz;
      ei = int'(e);
      r = mk(8'h00, 8'h00, s, 1'b0, 1'b0, 1'b0, 1);
      if (m == 9'h000) begin
         r.sign = 1'b0;
         r.zero = 1'b1;
      end else if (m[8]) begin
         if (ei >= 254) begin
            r.expo = 8'hFF;
            r.ovf  = 1'b1;
         end else begin
            r.mant = m[8:1];
            r.expo = 8'(ei + 1);
         end
      end else if (ei == 0) begin
         r.mant = m[7:0];
      end else begin
         lz = 8;
         for (int i = 0; i < 8; i++) if (m[i]) lz = 7 - i;
         if (lz <= ei - 1) begin
            r.mant = m[7:0] << lz;
            r.expo = 8'(ei - lz);
            r.lat  = lz + 1;
         end else begin
            r.mant = m[7:0] << (ei - 1);
            r.unf  = 1'b1;
            r.lat  = ei;
         end
      end
      return r;
   endfunction

   // Output monitor: compare each result against the scoreboard when OutValid rises.
   always @(negedge Clk) begin
      if (OutValid && !prev_v) begin
         if (q.size() == 0) begin
            check_eq("spurious_valid", {31'b0, OutValid}, 32'd0);
         end else begin
            mon_e = q.pop_front();
            check_eq("mant",      {24'b0, OutMantissa}, {24'b0, mon_e.mant});
            check_eq("exp",       {24'b0, OutExponent}, {24'b0, mon_e.expo});
            check_eq("sign",      {31'b0, OutSign},     {31'b0, mon_e.sign});
            check_eq("zero",      {31'b0, Zero},        {31'b0, mon_e.zero});
            check_eq("overflow",  {31'b0, Overflow},    {31'b0, mon_e.ovf});
            check_eq("underflow", {31'b0, Underflow},   {31'b0, mon_e.unf});
            check_eq("latency",   cyc - mon_e.acc,      mon_e.lat);
         end
      end
      prev_v = OutValid;
   end

   // Drive one operand; returns the edge count at which it was accepted.
   task automatic send(input logic [8:0] m, input logic [7:0] e, input logic s,
                       input bit track, input exp_t ex, output int acc);
      int n;
      n = 0;
      while (!InReady && n < 50) begin
         @(negedge Clk);
         n++;
      end
      if (n >= 50) check_eq("ready_timeout", {31'b0, InReady}, 32'd1);
      InMantissa = m;
      InExponent = e;
      InSign     = s;
      InValid    = 1'b1;
      @(posedge Clk);
      #1;
      InValid = 1'b0;
      acc = cyc;
      if (track) begin
         ex.acc = acc;
         q.push_back(ex);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge Clk);
      while ((q.size() != 0 || OutValid) && n < 100) begin
         @(negedge Clk);
         n++;
      end
      check_eq("drain_timeout", q.size(), 32'd0);
   endtask

   initial begin
      int         acc;
      int         rel;
      int         n;
      logic [8:0] rm;
      logic [7:0] re;
      logic [7:0] h_mant;
      logic [7:0] h_exp;

      ResetN = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      InMantissa = 9'h000; InExponent = 8'h00; InSign = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check_eq("rst_valid", {31'b0, OutValid},    32'd0);
      check_eq("rst_ready", {31'b0, InReady},     32'd1);
      check_eq("rst_mant",  {24'b0, OutMantissa}, 32'd0);
      check_eq("rst_exp",   {24'b0, OutExponent}, 32'd0);
      check_eq("rst_flags", {29'b0, Zero, Overflow, Underflow}, 32'd0);
      ResetN = 1'b1;
      @(negedge Clk);

      // Directed cases with hand-derived expectations.
      send(9'h016, 8'd10,  1'b1, 1'b1, mk(8'hB0, 8'd7,   1'b1, 1'b0, 1'b0, 1'b0, 4), acc); drain();
      send(9'h180, 8'd20,  1'b0, 1'b1, mk(8'hC0, 8'd21,  1'b0, 1'b0, 1'b0, 1'b0, 1), acc); drain();
      send(9'h100, 8'd254, 1'b0, 1'b1, mk(8'h00, 8'hFF,  1'b0, 1'b0, 1'b1, 1'b0, 1), acc); drain();
      send(9'h000, 8'd50,  1'b1, 1'b1, mk(8'h00, 8'h00,  1'b0, 1'b1, 1'b0, 1'b0, 1), acc); drain();
      send(9'h004, 8'd3,   1'b0, 1'b1, mk(8'h10, 8'h00,  1'b0, 1'b0, 1'b0, 1'b1, 3), acc); drain();
      send(9'h1FF, 8'd253, 1'b1, 1'b1, mk(8'hFF, 8'd254, 1'b1, 1'b0, 1'b0, 1'b0, 1), acc); drain();
      send(9'h180, 8'd255, 1'b1, 1'b1, mk(8'h00, 8'hFF,  1'b1, 1'b0, 1'b1, 1'b0, 1), acc); drain();
      send(9'h055, 8'd0,   1'b1, 1'b1, mk(8'h55, 8'h00,  1'b1, 1'b0, 1'b0, 1'b0, 1), acc); drain();
      send(9'h001, 8'd8,   1'b0, 1'b1, mk(8'h80, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 8), acc); drain();
      send(9'h040, 8'd1,   1'b1, 1'b1, mk(8'h40, 8'h00,  1'b1, 1'b0, 1'b0, 1'b1, 1), acc); drain();
      send(9'h0C3, 8'd1,   1'b0, 1'b1, mk(8'hC3, 8'd1,   1'b0, 1'b0, 1'b0, 1'b0, 1), acc); drain();

      // Handshake: hold OutReady low in DONE while pulsing InValid.
      OutReady = 1'b0;
      send(9'h016, 8'd10, 1'b1, 1'b1, mk(8'hB0, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4), acc);
      n = 0;
      while (!OutValid && n < 50) begin
         @(negedge Clk);
         n++;
      end
      check_eq("hs_reach_done", {31'b0, OutValid}, 32'd1);
      h_mant = OutMantissa;
      h_exp  = OutExponent;
      for (int i = 0; i < 5; i++) begin
         InMantissa = 9'h001 + 9'(i);
         InExponent = 8'd100;
         InSign     = 1'b0;
         InValid    = 1'b1;
         @(posedge Clk);
         @(negedge Clk);
         check_eq("hs_hold_valid", {31'b0, OutValid},    32'd1);
         check_eq("hs_inready",    {31'b0, InReady},     32'd0);
         check_eq("hs_hold_mant",  {24'b0, OutMantissa}, {24'b0, h_mant});
         check_eq("hs_hold_exp",   {24'b0, OutExponent}, {24'b0, h_exp});
         check_eq("hs_hold_sign",  {31'b0, OutSign},     32'd1);
      end
      InValid  = 1'b0;
      OutReady = 1'b1;
      @(posedge Clk);
      #1;
      rel = cyc;
      @(negedge Clk);
      check_eq("hs_idle_ready", {31'b0, InReady},  32'd1);
      check_eq("hs_idle_valid", {31'b0, OutValid}, 32'd0);
      send(9'h180, 8'd20, 1'b0, 1'b1, mk(8'hC0, 8'd21, 1'b0, 1'b0, 1'b0, 1'b0, 1), acc);
      check_eq("hs_reaccept_edge", acc, rel + 1);
      drain();

      // Reset during NORM aborts the operand with no OutValid.
      send(9'h016, 8'd10, 1'b1, 1'b0, mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0), acc);
      @(negedge Clk);
      ResetN = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      check_eq("abort_ready", {31'b0, InReady},     32'd1);
      check_eq("abort_valid", {31'b0, OutValid},    32'd0);
      check_eq("abort_mant",  {24'b0, OutMantissa}, 32'd0);
      check_eq("abort_exp",   {24'b0, OutExponent}, 32'd0);
      check_eq("abort_sign",  {31'b0, OutSign},     32'd0);
      ResetN = 1'b1;
      repeat (8) @(negedge Clk);
      send(9'h016, 8'd10, 1'b1, 1'b1, mk(8'hB0, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0, 4), acc); drain();

      // Random operands checked against the reference model.
      for (int i = 0; i < 40; i++) begin
         rm = 9'($urandom_range(0, 511));
         if (i % 3 == 0) rm = rm >> $urandom_range(1, 8);
         re = 8'($urandom_range(0, 255));
         if (i % 4 == 0) re = 8'($urandom_range(0, 6));
         send(rm, re, 1'($urandom_range(0, 1)), 1'b1, model(rm, re, 1'b0), acc);
         q[q.size()-1].sign = (rm == 9'h000) ? 1'b0 : InSign;
         drain();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sequential_normalizer.md
Name: sequential_normalizer

Overview:
- Multi-cycle post-add/sub normalizer for the Floating Point Unit Add_Sub path. It sits downstream of the significand compare/swap/subtract stage.
- Takes the raw significand result, which may carry out or carry leading zeros, plus the tentative exponent and sign.
- Produces a normalized significand and adjusted exponent, with Zero/Overflow/Underflow flags.
- Left shifts run one bit per clock under an FSM, with valid/ready handshakes on both sides.

Parameters:
- MantSize, 8, significand width including hidden bit (output width; input is MantSize+1 with carry bit).
- ExpSize, 8, exponent width; all-ones exponent encodes overflow/infinity.

Ports:
- Clk  input  1  clock, all state updates on rising edge.
- ResetN  input  1  reset, synchronous, active-low.
- InValid  input  1  upstream result valid.
- InReady  output  1  block can accept; equals (state==IDLE).
- InMantissa  input  MantSize+1  raw significand; bit MantSize is the carry-out.
- InExponent  input  ExpSize  tentative (larger) exponent.
- InSign  input  1  result sign from compare stage.
- OutValid  output  1  normalized result valid; equals (state==DONE).
- OutReady  input  1  downstream accepts result.
- OutMantissa  output  MantSize  normalized significand.
- OutExponent  output  ExpSize  adjusted exponent.
- OutSign  output  1  result sign.
- Zero  output  1  result is exactly zero.
- Overflow  output  1  exponent saturated to all-ones.
- Underflow  output  1  result denormal (shifting stopped at exponent floor).

Behaviour:
- States: IDLE, NORM, DONE.
- Reset: on any edge with ResetN=0, state=IDLE; all outputs and working regs are cleared to 0. InReady is 1 from the following cycle. Reset mid-NORM or mid-DONE discards the operation, and no OutValid is produced for it.
- Accept in IDLE when InValid=1 and ResetN=1 at the edge:
  - Latch InMantissa into the working mantissa M, InExponent into E, and InSign into S.
  - Clear the flags and go to NORM.
- NORM evaluates once per cycle, in priority order:
  1. M==0: OutMantissa=0, OutExponent=0, OutSign=0, Zero=1; go to DONE.
  2. M[MantSize]=1 (carry):
     - If E >= 2^ExpSize-2: OutExponent=all-ones, OutMantissa=0, Overflow=1.
     - Else: OutMantissa=M[MantSize:1] (LSB truncated), OutExponent=E+1.
     - Go to DONE.
  3. E==0: pass M[MantSize-1:0] and E through unchanged, no flags; go to DONE.
  4. M[MantSize-1]=1: output M[MantSize-1:0] and E; go to DONE.
  5. E==1: output M[MantSize-1:0], OutExponent=0, Underflow=1; go to DONE.
  6. Otherwise: M<=M<<1, E<=E-1, stay in NORM.
- Latency: with k left shifts, DONE is entered k+1 edges after the accept edge. Maximum k is MantSize-1.
- OutSign=S in every case except Zero, which forces 0.
- DONE: OutValid=1, and all outputs are held stable until an edge with OutReady=1. That edge returns the block to IDLE.
- Outputs keep their last values in IDLE and NORM, and are valid only while OutValid=1.
- InReady=0 outside IDLE; InValid is ignored there, with no queuing. No accept occurs in the same cycle as a DONE handoff; the earliest re-accept is the edge after returning to IDLE.
- All arithmetic is unsigned modulo field width; exponent adjustment never wraps because of rules 2 and 5.

Test Plan (MantSize=8, ExpSize=8):
- Shift case: InMantissa=0x016, InExponent=10, InSign=1 -> OutMantissa=0xB0, OutExponent=7, OutSign=1, no flags; OutValid rises 4 edges after accept (k=3).
- Carry and overflow:
  - 0x180/exp 20 -> OutMantissa=0xC0, exp 21, DONE after 1 edge.
  - 0x100/exp 254 -> exp 255, OutMantissa=0, Overflow=1.
- Zero: InMantissa=0x000, InExponent=50, InSign=1 -> Zero=1, OutExponent=0, OutMantissa=0, OutSign=0.
- Underflow: InMantissa=0x004, InExponent=3 -> OutMantissa=0x10, OutExponent=0, Underflow=1; DONE 3 edges after accept.
- Handshake: hold OutReady=0 for 5 cycles in DONE while pulsing InValid -> outputs stable, InReady=0, no accept. Then raise OutReady=1 -> IDLE next edge, and a new operand is accepted on the following edge.
- Reset: assert ResetN=0 for 1 edge during NORM of case 1 -> all outputs 0, state IDLE. No OutValid appears for the aborted operand, and the next operand normalizes correctly.
